// File: rtl/mem_reinit_ctrl.sv
// rtl/mem_reinit_ctrl.sv - RAM reinit sequencer with constant/stream fill and readback verify
module mem_reinit_ctrl #(
    parameter int WID_MEM   = 1,
    parameter int DEPTH_MEM = 32768,
    parameter int VERIFY_EN = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [WID_MEM-1:0] fill_val,
    input  logic               s_valid,
    input  logic [WID_MEM-1:0] s_data,
    output logic               s_ready,
    input  logic               usr_we,
    input  logic [31:0]        usr_waddr,
    input  logic [WID_MEM-1:0] usr_din,
    input  logic [31:0]        usr_raddr,
    output logic [WID_MEM-1:0] usr_dout,
    output logic               usr_rdy,
    output logic               mem_we,
    output logic [31:0]        mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic [31:0]        mem_raddr,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic               busy,
    output logic               done,
    output logic [31:0]        err_cnt,
    output logic               err
);

    localparam int            AW   = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH_MEM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [AW-1:0]      wa;
    logic [AW-1:0]      ra;
    logic               cmp_v;
    logic               mode_q;
    logic [WID_MEM-1:0] fill_q;
    logic [31:0]        err_cnt_q;
    logic               wr_fire;
    logic               mismatch;

    // A sweep write happens every cycle in CONST mode, only on a handshake in STREAM mode
    assign wr_fire  = (state == S_WRITE) && (mode_q ? s_valid : 1'b1);
    // cmp_v marks that mem_dout now carries the data of last cycle's verify read
    assign mismatch = cmp_v && (mem_dout != fill_q);

    assign usr_dout = mem_dout;
    assign err_cnt  = err_cnt_q;
    assign err      = (err_cnt_q != 32'd0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Sweep counters, start-time latches and the saturating mismatch counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wa        <= '0;
            ra        <= '0;
            cmp_v     <= 1'b0;
            mode_q    <= 1'b0;
            fill_q    <= '0;
            err_cnt_q <= 32'd0;
        end else begin
            cmp_v <= (state == S_VERIFY);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        fill_q    <= fill_val;
                        err_cnt_q <= 32'd0;
                        wa        <= '0;
                        ra        <= '0;
                    end
                end
                S_WRITE: begin
                    if (wr_fire) begin
                        wa <= wa + AW'(1);
                    end
                end
                S_VERIFY: begin
                    ra <= ra + AW'(1);
                    if (mismatch && (err_cnt_q != 32'hFFFF_FFFF)) begin
                        err_cnt_q <= err_cnt_q + 32'd1;
                    end
                end
                S_DRAIN: begin
                    if (mismatch && (err_cnt_q != 32'hFFFF_FFFF)) begin
                        err_cnt_q <= err_cnt_q + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and RAM/user port muxing; the user port owns the RAM only in IDLE
    always_comb begin
        state_nx  = state;
        mem_we    = 1'b0;
        mem_waddr = 32'(wa);
        mem_din   = fill_q;
        mem_raddr = 32'(ra);
        s_ready   = 1'b0;
        usr_rdy   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                usr_rdy   = 1'b1;
                mem_we    = usr_we;
                mem_waddr = usr_waddr;
                mem_din   = usr_din;
                mem_raddr = usr_raddr;
                if (start) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                busy    = 1'b1;
                s_ready = mode_q;
                mem_we  = wr_fire;
                mem_din = mode_q ? s_data : fill_q;
                if (wr_fire && (wa == LAST)) begin
                    state_nx = ((VERIFY_EN != 0) && !mode_q) ? S_VERIFY : S_DONE;
                end
            end
            S_VERIFY: begin
                busy = 1'b1;
                if (ra == LAST) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_reinit_ctrl.sv
// tb/tb_mem_reinit_ctrl.sv - scoreboard bench for mem_reinit_ctrl
module tb_mem_reinit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic        mode;
    logic [7:0]  fill_val;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        usr_we;
    logic [31:0] usr_waddr, usr_raddr;
    logic [7:0]  usr_din;

    logic        s_ready0, usr_rdy0, mem_we0, busy0, done0, err0;
    logic [7:0]  usr_dout0, mem_din0, mem_dout0;
    logic [31:0] mem_waddr0, mem_raddr0, err_cnt0;
    logic        s_ready1, usr_rdy1, mem_we1, busy1, done1, err1;
    logic [7:0]  usr_dout1, mem_din1, mem_dout1;
    logic [31:0] mem_waddr1, mem_raddr1, err_cnt1;

    always #5 clk = ~clk;

    mem_reinit_ctrl #(.WID_MEM(8), .DEPTH_MEM(16), .VERIFY_EN(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode), .fill_val(fill_val),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready0),
        .usr_we(usr_we), .usr_waddr(usr_waddr), .usr_din(usr_din), .usr_raddr(usr_raddr),
        .usr_dout(usr_dout0), .usr_rdy(usr_rdy0),
        .mem_we(mem_we0), .mem_waddr(mem_waddr0), .mem_din(mem_din0), .mem_raddr(mem_raddr0),
        .mem_dout(mem_dout0), .busy(busy0), .done(done0), .err_cnt(err_cnt0), .err(err0)
    );

    mem_reinit_ctrl #(.WID_MEM(8), .DEPTH_MEM(16), .VERIFY_EN(0)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .mode(mode), .fill_val(fill_val),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1),
        .usr_we(usr_we), .usr_waddr(usr_waddr), .usr_din(usr_din), .usr_raddr(usr_raddr),
        .usr_dout(usr_dout1), .usr_rdy(usr_rdy1),
        .mem_we(mem_we1), .mem_waddr(mem_waddr1), .mem_din(mem_din1), .mem_raddr(mem_raddr1),
        .mem_dout(mem_dout1), .busy(busy1), .done(done1), .err_cnt(err_cnt1), .err(err1)
    );

    // RAM models: 1-cycle registered read; ram0 can corrupt one address on controller writes
    logic [7:0] ram0 [16];
    logic [7:0] ram1 [16];
    int         corrupt_addr = -1;

    always @(posedge clk) begin
        if (mem_we0) begin
            if (!usr_rdy0 && (corrupt_addr == int'(mem_waddr0[3:0])))
                ram0[mem_waddr0[3:0]] <= 8'h00;
            else
                ram0[mem_waddr0[3:0]] <= mem_din0;
        end
        mem_dout0 <= ram0[mem_raddr0[3:0]];
        if (mem_we1) ram1[mem_waddr1[3:0]] <= mem_din1;
        mem_dout1 <= ram1[mem_raddr1[3:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; logic [7:0] data; } wr_t;
    typedef struct { int cyc; logic [31:0] err; } dn_t;
    wr_t        exp_wr[$];
    dn_t        exp_done[$];
    logic [7:0] ref_ram [16];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every RAM write and every done pulse of dut0 is matched against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we0) begin
                if (exp_wr.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", mem_waddr0, 32'(w.addr));
                    chk("wr_data", 32'(mem_din0), 32'(w.data));
                end
            end
            if (done0) begin
                if (exp_done.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    dn_t d;
                    d = exp_done.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d.cyc));
                    chk("err_cnt", err_cnt0, d.err);
                    chk("err", 32'(err0), 32'(d.err != 0));
                    chk("busy_at_done", 32'(busy0), 32'd0);
                    chk("usr_rdy_at_done", 32'(usr_rdy0), 32'd0);
                end
            end
        end
    end

    task automatic wait_done(input int limit);
        while (exp_done.size() != 0 && cyc < limit) tick;
        if (exp_done.size() != 0) begin
            fail("done_timeout");
            exp_done.delete();
        end
        chk("writes_pending", 32'(exp_wr.size()), 32'd0);
        exp_wr.delete();
        tick;
        tick;
    endtask

    task automatic const_run(input logic [7:0] fill, input int corrupt, input bit user_hold,
                             input bit restart_mid);
        int n;
        int e;
        corrupt_addr = corrupt;
        tick;
        start0 = 1'b1; mode = 1'b0; fill_val = fill; n = cyc;
        if (user_hold) begin
            usr_we = 1'b1; usr_waddr = 32'd3; usr_din = 8'h3C;
            exp_wr.push_back('{3, 8'h3C});
            ref_ram[3] = 8'h3C;
        end
        for (int a = 0; a < 16; a++) begin
            exp_wr.push_back('{a, fill});
            ref_ram[a] = (a == corrupt) ? 8'h00 : fill;
        end
        e = 0;
        for (int a = 0; a < 16; a++) if (ref_ram[a] != fill) e++;
        exp_done.push_back('{n + 34, 32'(e)});
        tick;
        start0 = 1'b0; mode = 1'b1; fill_val = 8'($urandom);
        while (exp_done.size() != 0 && cyc < n + 80) begin
            tick;
            if (cyc == n + 17) usr_we = 1'b0;
            start0 = restart_mid && (cyc == n + 20);
        end
        start0 = 1'b0;
        wait_done(n + 80);
        corrupt_addr = -1;
    endtask

    task automatic stream_run(input bit alt);
        logic [7:0] data [16];
        int n;
        int idx;
        int step;
        for (int i = 0; i < 16; i++) begin
            data[i] = alt ? 8'(i) : 8'($urandom);
            exp_wr.push_back('{i, data[i]});
            ref_ram[i] = data[i];
        end
        tick;
        start0 = 1'b1; mode = 1'b1; fill_val = 8'($urandom); n = cyc;
        tick;
        start0 = 1'b0;
        idx = 0;
        step = 0;
        while (idx < 16 && cyc < n + 200) begin
            s_valid = alt ? (step % 2 == 0) : 1'($urandom_range(0, 1));
            s_data  = data[idx];
            step++;
            @(negedge clk);
            if (s_valid && s_ready0) begin
                idx++;
                if (idx == 16) exp_done.push_back('{cyc + 1, 32'd0});
            end
            tick;
        end
        s_valid = 1'b0;
        if (idx < 16) fail("stream_timeout");
        wait_done(n + 220);
    endtask

    task automatic check_ram;
        for (int a = 0; a < 16; a++) begin
            tick;
            usr_raddr = 32'(a);
            tick;
            @(negedge clk);
            chk("ram_readback", 32'(usr_dout0), 32'(ref_ram[a]));
        end
    endtask

    task automatic reset_mid(input logic [7:0] fill);
        int n;
        tick;
        start0 = 1'b1; mode = 1'b0; fill_val = fill; n = cyc;
        for (int a = 0; a < 10; a++) begin
            exp_wr.push_back('{a, fill});
            ref_ram[a] = fill;
        end
        tick;
        start0 = 1'b0;
        while (cyc < n + 10) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy0), 32'd0);
        chk("rst_mid_mem_we", 32'(mem_we0), 32'd0);
        chk("rst_mid_usr_rdy", 32'(usr_rdy0), 32'd1);
        chk("rst_mid_done", 32'(done0), 32'd0);
        repeat (40) tick;
        chk("rst_mid_writes", 32'(exp_wr.size()), 32'd0);
        exp_wr.delete();
    endtask

    task automatic run_dut1(input logic [7:0] fill);
        tick;
        start1 = 1'b1; mode = 1'b0; fill_val = fill;
        tick;
        start1 = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            start1 = (k == 5);
            @(negedge clk);
            chk("v0_mem_we", 32'(mem_we1), 32'(k <= 16));
            if (k <= 16) begin
                chk("v0_waddr", mem_waddr1, 32'(k - 1));
                chk("v0_din", 32'(mem_din1), 32'(fill));
            end
            chk("v0_done", 32'(done1), 32'(k == 17));
            chk("v0_busy", 32'(busy1), 32'(k <= 16));
            tick;
        end
        start1 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; mode = 1'b0; fill_val = 8'h00;
        s_valid = 1'b0; s_data = 8'h00; usr_we = 1'b0; usr_waddr = 32'd0;
        usr_din = 8'h00; usr_raddr = 32'd0;
        for (int a = 0; a < 16; a++) ref_ram[a] = 8'h00;
        repeat (3) tick;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_err_cnt", err_cnt0, 32'd0);
        chk("rst_s_ready", 32'(s_ready0), 32'd0);
        chk("rst_mem_we", 32'(mem_we0), 32'd0);
        chk("rst_usr_rdy", 32'(usr_rdy0), 32'd1);
        chk("rst_busy_v0", 32'(busy1), 32'd0);
        mon_en = 1'b1;

        const_run(8'hA5, -1, 1'b0, 1'b0);
        const_run(8'hA5, 7, 1'b0, 1'b0);
        check_ram;
        stream_run(1'b1);
        check_ram;
        const_run(8'($urandom_range(1, 255)), -1, 1'b1, 1'b1);
        check_ram;
        reset_mid(8'h5A);
        const_run(8'($urandom), -1, 1'b0, 1'b0);
        check_ram;
        run_dut1(8'($urandom));
        stream_run(1'b0);
        check_ram;
        for (int r = 0; r < 3; r++) begin
            const_run(8'($urandom), $urandom_range(0, 15), 1'b0, 1'b0);
            check_ram;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
